// File: rtl/time_entry_encoder.sv
// -----------------------------------------------------------------------------
// time_entry_encoder
//
// Purpose: debounces a microwave-style keypad and turns accepted key presses
// into a three-digit BCD cook time (M:SS). Digits shift in from the right,
// CLEAR zeroes the entry, and START either launches a cook run (one-clock
// start pulse, then the entry clears) or is rejected with a one-clock err
// pulse when the seconds are invalid or the entry is empty.
//
// Parameter:
//   STABLE_CYCLES  clocks a key must stay stable before it is accepted (1-255)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   key_valid  in   high while a key is pressed
//   key_code   in   [3:0] 0-9 digit, 10 CLEAR, 11 START, 12-15 unused
//   min        out  [3:0] minutes digit (registered BCD)
//   sec_tens   out  [3:0] tens-of-seconds digit (registered BCD)
//   sec_ones   out  [3:0] ones-of-seconds digit (registered BCD)
//   start      out  one-clock cook-run request
//   err        out  one-clock pulse on a rejected START
//   digit_cnt  out  [1:0] digits entered so far (0-3)
//
// Optional feature macro: ADD30_QUICKSTART_EN
//   When defined, START on an empty entry loads 0:30 and launches instead of
//   raising err.
// -----------------------------------------------------------------------------
module time_entry_encoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] min,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       start,
  output logic       err,
  output logic [1:0] digit_cnt
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_e;

  // The counter is loaded with 1 on the first sampled clock, so a key is
  // accepted on the clock whose increment would bring it to STABLE_CYCLES.
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 32'd1);

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_START = 4'd11;

  state_e     state_q, state_d;
  logic [3:0] key_q, key_d;
  logic [7:0] cnt_q, cnt_d;
  logic       accept_s;

  logic [3:0] min_q, min_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [1:0] dcnt_q, dcnt_d;
  logic       start_q, start_d;
  logic       err_q, err_d;

  function automatic logic all_zero(input logic [3:0] m, input logic [3:0] t,
                                    input logic [3:0] o);
    return (m == 4'd0) && (t == 4'd0) && (o == 4'd0);
  endfunction

  // Debounce state machine: next state, latched key, stability counter.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          key_d   = key_code;
          cnt_d   = 8'd1;
          state_d = DEBOUNCE;
        end else begin
          cnt_d = 8'd0;
        end
      end
      DEBOUNCE: begin
        if (key_valid && (key_code == key_q)) begin
          // Saturate rather than wrap.
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d = cnt_q;
          end
          if (cnt_q >= STABLE_LAST) begin
            accept_s = 1'b1;
            state_d  = WAIT_RELEASE;
          end else begin
            state_d = DEBOUNCE;
          end
        end else begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end
      end
      WAIT_RELEASE: begin
        if (!key_valid) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          state_d = WAIT_RELEASE;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Entry datapath: act on an accepted key, or clear after a start pulse.
  always_comb begin
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    dcnt_d  = dcnt_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    if (start_q) begin
      // The clock showing the start pulse carries the launched time; the
      // entry empties on the following edge.
      min_d  = 4'd0;
      tens_d = 4'd0;
      ones_d = 4'd0;
      dcnt_d = 2'd0;
    end else if (accept_s) begin
      case (key_q)
        KEY_CLEAR: begin
          min_d  = 4'd0;
          tens_d = 4'd0;
          ones_d = 4'd0;
          dcnt_d = 2'd0;
        end
        KEY_START: begin
          if (tens_q > 4'd5) begin
            err_d = 1'b1;
          end else if (all_zero(min_q, tens_q, ones_q)) begin
`ifdef ADD30_QUICKSTART_EN
            tens_d  = 4'd3;
            start_d = 1'b1;
`else
            err_d = 1'b1;
`endif
          end else begin
            start_d = 1'b1;
          end
        end
        default: begin
          // Digits shift in from the right; a fourth digit and codes 12-15
          // leave the entry untouched.
          if ((key_q <= 4'd9) && (dcnt_q != 2'd3)) begin
            min_d  = tens_q;
            tens_d = ones_q;
            ones_d = key_q;
            dcnt_d = dcnt_q + 2'd1;
          end else begin
            dcnt_d = dcnt_q;
          end
        end
      endcase
    end else begin
      dcnt_d = dcnt_q;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= 4'd0;
      cnt_q   <= 8'd0;
      min_q   <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      dcnt_q  <= 2'd0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      dcnt_q  <= dcnt_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  assign min       = min_q;
  assign sec_tens  = tens_q;
  assign sec_ones  = ones_q;
  assign digit_cnt = dcnt_q;
  assign start     = start_q;
  assign err       = err_q;

endmodule
